trace_sequencer_multi: RTL and testbench

//  Parametrised stimulus generator for formal/SVA testcases: plays NCH character-string

---
 rtl/trace_seq_pkg.sv | 37 +++
 rtl/trace_sequencer_multi_if.sv | 41 ++++
 rtl/trace_seq_lane.sv | 52 +++++
 rtl/trace_sequencer_multi.sv | 98 +++++++++
 tb/tb_trace_sequencer_multi.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_seq_pkg.sv
// ----------------------------------------------------------------------------
// trace_seq_pkg
// Shared constants and helpers for the trace sequencer.
//   CHAR_HI / CHAR_HI_ALT : characters that decode to logic 1 ("-" and "1")
//   CHAR_LO               : idle character "_" (decodes to 0, as does any other byte)
//   MAX_LEN               : longest trace (in characters) that char_at can address
//   char_at(str,len,idx)  : byte at character index idx (0 = leftmost) of a
//                           right-aligned len-character string
//   is_high(c)            : decode of one trace character
// Optional feature macro used elsewhere in this slice: TRACE_SEQ_HICNT_EN.
// ----------------------------------------------------------------------------
package trace_seq_pkg;

    localparam logic [7:0] CHAR_HI     = "-";
    localparam logic [7:0] CHAR_HI_ALT = "1";
    localparam logic [7:0] CHAR_LO     = "_";

    // Strings are zero-extended to this many characters before indexing, so
    // one function serves every LEN up to this bound.
    localparam int MAX_LEN = 1024;

    function automatic logic [7:0] char_at(input logic [MAX_LEN*8-1:0] str,
                                           input int len, input int idx);
        return str[8*(len-1-idx) +: 8];
    endfunction

    function automatic logic is_high(input logic [7:0] c);
        logic hi;
        case (c)
            CHAR_HI, CHAR_HI_ALT: hi = 1'b1;
            CHAR_LO:              hi = 1'b0;
            default:              hi = 1'b0;
        endcase
        return hi;
    endfunction

endpackage

// File: rtl/trace_sequencer_multi_if.sv
// ----------------------------------------------------------------------------
// trace_sequencer_multi_if
// Control/status bundle of the trace sequencer.
//   en, restart  : advance / return-to-start requests (from the controller)
//   out[NCH]     : decoded trace bits at the current index
//   t_idx        : current character index
//   done         : end of trace reached (hold mode)
//   wrap_pulse   : one-cycle flag after a loop-back (loop mode)
//   hi_cnt       : per-lane high-cycle counters, lane k at [k*CNTW +: CNTW]
//                  (only when TRACE_SEQ_HICNT_EN is defined)
// Modports: master = controller driving en/restart, slave = sequencer.
// ----------------------------------------------------------------------------
interface trace_sequencer_multi_if #(
    parameter int NCH  = 4,
    parameter int LEN  = 32,
    parameter int CNTW = 16
);
    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

    logic           en;
    logic           restart;
    logic [NCH-1:0] out;
    logic [IW-1:0]  t_idx;
    logic           done;
    logic           wrap_pulse;

`ifdef TRACE_SEQ_HICNT_EN
    logic [NCH*CNTW-1:0] hi_cnt;

    modport master (output en, restart, input out, t_idx, done, wrap_pulse, hi_cnt);
    modport slave  (input en, restart, output out, t_idx, done, wrap_pulse, hi_cnt);
`else
    modport master (output en, restart, input out, t_idx, done, wrap_pulse);
    modport slave  (input en, restart, output out, t_idx, done, wrap_pulse);
`endif

    if (CNTW < 1) begin : g_bad_cntw
        $error("trace_sequencer_multi_if: CNTW must be >= 1");
    end

endinterface

// File: rtl/trace_seq_lane.sv
// ----------------------------------------------------------------------------
// trace_seq_lane
// One output channel: decodes the character of its trace string at t_idx.
//   str     : LEN characters, leftmost character in the top byte
//   t_idx   : current character index (shared by all lanes)
//   hi      : decoded bit, combinational from t_idx
// With TRACE_SEQ_HICNT_EN defined it also keeps a saturating count of the
// advancing edges on which hi was 1 (ports clock, reset, en, restart, hi_cnt).
// ----------------------------------------------------------------------------
module trace_seq_lane
    import trace_seq_pkg::*;
#(
    parameter int LEN = 32
`ifdef TRACE_SEQ_HICNT_EN
    , parameter int CNTW = 16
`endif
) (
`ifdef TRACE_SEQ_HICNT_EN
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              restart,
    output logic [CNTW-1:0]                   hi_cnt,
`endif
    input  logic [LEN*8-1:0]                  str,
    input  logic [((LEN>1)?$clog2(LEN):1)-1:0] t_idx,
    output logic                              hi
);
    localparam int SW = MAX_LEN * 8;

    logic [SW-1:0] str_ext;

    assign str_ext = SW'(str);
    assign hi      = is_high(char_at(str_ext, LEN, int'(t_idx)));

`ifdef TRACE_SEQ_HICNT_EN
    logic [CNTW-1:0] cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (restart) begin
            cnt_reg <= '0;
        end else if (en && hi && (cnt_reg != {CNTW{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign hi_cnt = cnt_reg;
`endif

endmodule

// File: rtl/trace_sequencer_multi.sv
// ----------------------------------------------------------------------------
// trace_sequencer_multi
// Plays NCH character-string traces, one character per clock, as NCH bits.
//   clock   : rising-edge clock
//   reset   : asynchronous, active-high; returns the index to 0
//   bus     : trace_sequencer_multi_if.slave (en, restart in; out, t_idx,
//             done, wrap_pulse and optionally hi_cnt out)
// Parameters: NCH channels, LEN characters per trace, WRAP (0 hold / 1 loop),
// TRACES (channel k at [(NCH-k)*LEN*8-1 -: LEN*8]), CNTW counter width.
// Optional feature macro: TRACE_SEQ_HICNT_EN (per-lane high-cycle counters).
// ----------------------------------------------------------------------------
module trace_sequencer_multi
    import trace_seq_pkg::*;
#(
    parameter int                  NCH    = 4,
    parameter int                  LEN    = 32,
    parameter int                  WRAP   = 0,
    parameter logic [NCH*LEN*8-1:0] TRACES = {NCH*LEN{"_"}},
    parameter int                  CNTW   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    trace_sequencer_multi_if.slave bus
);
    localparam int            IW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(LEN - 1);

    logic [IW-1:0]  t_idx_reg, t_idx_next;
    logic           wrap_reg, wrap_next;
    logic [NCH-1:0] out_bits;

    // Restart beats en; the last index either saturates or loops back, and the
    // comparison against LAST (not the all-ones value) handles non-power-of-2 LEN.
    always_comb begin
        t_idx_next = t_idx_reg;
        wrap_next  = 1'b0;
        if (bus.restart) begin
            t_idx_next = '0;
        end else if (bus.en) begin
            if (t_idx_reg == LAST) begin
                if (WRAP != 0) begin
                    t_idx_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                t_idx_next = t_idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_idx_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            t_idx_reg <= t_idx_next;
            wrap_reg  <= wrap_next;
        end
    end

`ifdef TRACE_SEQ_HICNT_EN
    logic [NCH*CNTW-1:0] hi_cnt_bits;
`endif

    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
        trace_seq_lane #(
            .LEN  (LEN)
`ifdef TRACE_SEQ_HICNT_EN
            , .CNTW (CNTW)
`endif
        ) u_lane (
`ifdef TRACE_SEQ_HICNT_EN
            .clock   (clock),
            .reset   (reset),
            .en      (bus.en),
            .restart (bus.restart),
            .hi_cnt  (hi_cnt_bits[gi*CNTW +: CNTW]),
`endif
            .str     (TRACES[(NCH-gi)*LEN*8-1 -: LEN*8]),
            .t_idx   (t_idx_reg),
            .hi      (out_bits[gi])
        );
    end

`ifdef TRACE_SEQ_HICNT_EN
    assign bus.hi_cnt = hi_cnt_bits;
`endif

    assign bus.out        = out_bits;
    assign bus.t_idx      = t_idx_reg;
    assign bus.wrap_pulse = wrap_reg;
    assign bus.done       = (WRAP == 0) && (t_idx_reg == LAST);

    if (NCH < 1 || LEN < 2 || LEN > MAX_LEN || CNTW < 1) begin : g_bad_params
        $error("trace_sequencer_multi: invalid NCH/LEN/CNTW");
    end

endmodule

// File: tb/tb_trace_sequencer_multi.sv
// ----------------------------------------------------------------------------
// tb_trace_sequencer_multi
// Directed bench for trace_sequencer_multi. Two instances share clock/reset:
//   dut_a : NCH=4, LEN=32, WRAP=0 (hold), CNTW=2
//   dut_b : NCH=1, LEN=5,  WRAP=1 (loop)
// Hi-count checks are compiled when TRACE_SEQ_HICNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_trace_sequencer_multi;

    localparam logic [32*8-1:0] CH0 = {"_-", {10{"_"}}, "-", {5{"_"}}, "-", {13{"_"}}};
    localparam logic [32*8-1:0] CH1 = {32{"-"}};
    localparam logic [32*8-1:0] CH2 = {"1a-0", {28{"_"}}};
    localparam logic [32*8-1:0] CH3 = {32{"_"}};
    localparam logic [4*32*8-1:0] TRACES_A = {CH0, CH1, CH2, CH3};
    localparam logic [5*8-1:0]    TRACES_B = "-____";

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    trace_sequencer_multi_if #(.NCH(4), .LEN(32), .CNTW(2))  bus_a ();
    trace_sequencer_multi_if #(.NCH(1), .LEN(5),  .CNTW(16)) bus_b ();

    trace_sequencer_multi #(
        .NCH(4), .LEN(32), .WRAP(0), .TRACES(TRACES_A), .CNTW(2)
    ) dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    trace_sequencer_multi #(
        .NCH(1), .LEN(5), .WRAP(1), .TRACES(TRACES_B), .CNTW(16)
    ) dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_a();
        bus_a.restart = 1'b1;
        bus_a.en      = 1'b0;
        tick();
        bus_a.restart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.en = 1'b0; bus_a.restart = 1'b0;
        bus_b.en = 1'b0; bus_b.restart = 1'b0;
        #3;
        checks++;
        if (bus_a.t_idx !== 5'd0) begin
            errors++; $display("FAIL reset_t_idx_a got %0d expected 0", bus_a.t_idx);
        end
        checks++;
        if (bus_a.out !== 4'b0110) begin
            errors++; $display("FAIL reset_out_a got %b expected 0110", bus_a.out);
        end
        checks++;
        if (bus_a.done !== 1'b0) begin
            errors++; $display("FAIL reset_done_a got %b expected 0", bus_a.done);
        end
        checks++;
        if (bus_b.t_idx !== 3'd0 || bus_b.wrap_pulse !== 1'b0 || bus_b.out !== 1'b1) begin
            errors++;
            $display("FAIL reset_b got t=%0d wrap=%b out=%b expected t=0 wrap=0 out=1",
                     bus_b.t_idx, bus_b.wrap_pulse, bus_b.out);
        end
`ifdef TRACE_SEQ_HICNT_EN
        checks++;
        if (bus_a.hi_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_hi_cnt got %h expected 00", bus_a.hi_cnt);
        end
`endif
        #9;
        rst = 1'b0;
        tick();
        checks++;
        if (bus_a.t_idx !== 5'd0) begin
            errors++; $display("FAIL reset_idle_t_idx got %0d expected 0", bus_a.t_idx);
        end
        $display("test_reset done");
    endtask

    // Hold-mode trace: out[0] high at 1,12,18; out[2] high at 0,2; saturate at 31.
    task automatic test_hold_trace();
        logic [4:0] exp_t;
        logic [3:0] exp_out;
        bus_a.en = 1'b1;
        for (int c = 0; c < 36; c++) begin
            exp_t   = (c < 31) ? 5'(c) : 5'd31;
            exp_out = {1'b0, (exp_t == 5'd0 || exp_t == 5'd2), 1'b1,
                       (exp_t == 5'd1 || exp_t == 5'd12 || exp_t == 5'd18)};
            checks++;
            if (bus_a.t_idx !== exp_t) begin
                errors++; $display("FAIL hold_t_idx c=%0d got %0d expected %0d", c, bus_a.t_idx, exp_t);
            end
            checks++;
            if (bus_a.out !== exp_out) begin
                errors++; $display("FAIL hold_out c=%0d got %b expected %b", c, bus_a.out, exp_out);
            end
            checks++;
            if (bus_a.done !== (exp_t == 5'd31)) begin
                errors++; $display("FAIL hold_done c=%0d got %b expected %b", c, bus_a.done, exp_t == 5'd31);
            end
            tick();
        end
        bus_a.en = 1'b0;
        $display("test_hold_trace done");
    endtask

    // Loop mode, LEN=5: index 0..4 repeating, wrap_pulse on cycles 5 and 10.
    task automatic test_loop();
        logic [2:0] exp_t;
        bus_b.en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            exp_t = 3'(c % 5);
            checks++;
            if (bus_b.t_idx !== exp_t) begin
                errors++; $display("FAIL loop_t_idx c=%0d got %0d expected %0d", c, bus_b.t_idx, exp_t);
            end
            checks++;
            if (bus_b.wrap_pulse !== (c == 5 || c == 10)) begin
                errors++; $display("FAIL loop_wrap c=%0d got %b expected %b", c, bus_b.wrap_pulse, c == 5 || c == 10);
            end
            checks++;
            if (bus_b.out !== (exp_t == 3'd0)) begin
                errors++; $display("FAIL loop_out c=%0d got %b expected %b", c, bus_b.out, exp_t == 3'd0);
            end
            checks++;
            if (bus_b.done !== 1'b0) begin
                errors++; $display("FAIL loop_done c=%0d got %b expected 0", c, bus_b.done);
            end
            tick();
        end
        bus_b.en = 1'b0;
        $display("test_loop done");
    endtask

    task automatic test_stall();
        logic       en_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [4:0] exp_seq[4] = '{5'd3, 5'd3, 5'd3, 5'd4};
        restart_a();
        bus_a.en = 1'b1;
        tick();
        tick();
        checks++;
        if (bus_a.t_idx !== 5'd2) begin
            errors++; $display("FAIL stall_start got %0d expected 2", bus_a.t_idx);
        end
        for (int i = 0; i < 4; i++) begin
            bus_a.en = en_seq[i];
            tick();
            checks++;
            if (bus_a.t_idx !== exp_seq[i] || bus_a.out !== 4'b0010) begin
                errors++;
                $display("FAIL stall_step%0d got t=%0d out=%b expected t=%0d out=0010",
                         i, bus_a.t_idx, bus_a.out, exp_seq[i]);
            end
        end
        bus_a.en = 1'b0;
        // Loop instance sits at index 2: two advances to 4, one wrap, then a stall.
        bus_b.en = 1'b1;
        tick();
        tick();
        checks++;
        if (bus_b.t_idx !== 3'd4 || bus_b.wrap_pulse !== 1'b0) begin
            errors++; $display("FAIL stall_b_last got t=%0d wrap=%b expected t=4 wrap=0", bus_b.t_idx, bus_b.wrap_pulse);
        end
        tick();
        checks++;
        if (bus_b.t_idx !== 3'd0 || bus_b.wrap_pulse !== 1'b1) begin
            errors++; $display("FAIL stall_b_wrap got t=%0d wrap=%b expected t=0 wrap=1", bus_b.t_idx, bus_b.wrap_pulse);
        end
        bus_b.en = 1'b0;
        tick();
        checks++;
        if (bus_b.t_idx !== 3'd0 || bus_b.wrap_pulse !== 1'b0) begin
            errors++; $display("FAIL stall_b_hold got t=%0d wrap=%b expected t=0 wrap=0", bus_b.t_idx, bus_b.wrap_pulse);
        end
        $display("test_stall done");
    endtask

    task automatic test_restart();
        restart_a();
        bus_a.en = 1'b1;
        repeat (20) tick();
        checks++;
        if (bus_a.t_idx !== 5'd20) begin
            errors++; $display("FAIL restart_pre got %0d expected 20", bus_a.t_idx);
        end
        bus_a.restart = 1'b1;
        bus_a.en      = 1'b1;
        tick();
        bus_a.restart = 1'b0;
        bus_a.en      = 1'b0;
        checks++;
        if (bus_a.t_idx !== 5'd0 || bus_a.done !== 1'b0) begin
            errors++; $display("FAIL restart_idx got t=%0d done=%b expected t=0 done=0", bus_a.t_idx, bus_a.done);
        end
        checks++;
        if (bus_a.out !== 4'b0110) begin
            errors++; $display("FAIL restart_out got %b expected 0110", bus_a.out);
        end
`ifdef TRACE_SEQ_HICNT_EN
        checks++;
        if (bus_a.hi_cnt !== 8'd0) begin
            errors++; $display("FAIL restart_hi_cnt got %h expected 00", bus_a.hi_cnt);
        end
`endif
        // Restart also clears done after saturation at the last index.
        bus_a.en = 1'b1;
        repeat (33) tick();
        checks++;
        if (bus_a.done !== 1'b1) begin
            errors++; $display("FAIL restart_done_set got %b expected 1", bus_a.done);
        end
        restart_a();
        checks++;
        if (bus_a.done !== 1'b0 || bus_a.t_idx !== 5'd0) begin
            errors++; $display("FAIL restart_done_clr got done=%b t=%0d expected 0/0", bus_a.done, bus_a.t_idx);
        end
        $display("test_restart done");
    endtask

    task automatic test_async_reset();
        restart_a();
        bus_a.en = 1'b1;
        repeat (9) tick();
        bus_a.en = 1'b0;
        bus_b.en = 1'b1;
        tick();
        bus_b.en = 1'b0;
        checks++;
        if (bus_a.t_idx !== 5'd9 || bus_b.t_idx !== 3'd1) begin
            errors++; $display("FAIL async_pre got a=%0d b=%0d expected 9/1", bus_a.t_idx, bus_b.t_idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_a.t_idx !== 5'd0 || bus_a.out !== 4'b0110 || bus_a.done !== 1'b0) begin
            errors++;
            $display("FAIL async_a got t=%0d out=%b done=%b expected t=0 out=0110 done=0",
                     bus_a.t_idx, bus_a.out, bus_a.done);
        end
        checks++;
        if (bus_b.t_idx !== 3'd0 || bus_b.out !== 1'b1) begin
            errors++; $display("FAIL async_b got t=%0d out=%b expected t=0 out=1", bus_b.t_idx, bus_b.out);
        end
        #1 rst = 1'b0;
        tick();
        checks++;
        if (bus_a.t_idx !== 5'd0) begin
            errors++; $display("FAIL async_post got %0d expected 0", bus_a.t_idx);
        end
        $display("test_async_reset done");
    endtask

`ifdef TRACE_SEQ_HICNT_EN
    // CNTW=2: lane 1 (always high) saturates at 3; lanes 0/2/3 see 1/2/0 highs in t=0..5.
    task automatic test_hicnt();
        logic [1:0] exp_seq[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        restart_a();
        bus_a.en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus_a.hi_cnt[3:2] !== exp_seq[i]) begin
                errors++; $display("FAIL hicnt_lane1 step%0d got %0d expected %0d", i, bus_a.hi_cnt[3:2], exp_seq[i]);
            end
        end
        bus_a.en = 1'b0;
        tick();
        checks++;
        if (bus_a.hi_cnt !== 8'b00_10_11_01) begin
            errors++; $display("FAIL hicnt_all got %b expected 00101101", bus_a.hi_cnt);
        end
        $display("test_hicnt done");
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_hold_trace();
        test_loop();
        test_stall();
        test_restart();
        test_async_reset();
`ifdef TRACE_SEQ_HICNT_EN
        test_hicnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
